// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - state encoding and operand-match helper for the pipeline hazard controller
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A load into $0 is architecturally discarded, so it can never feed a consumer.
  function automatic logic operand_match(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic uses_rs, input logic uses_rt,
                                         input logic [4:0] dst);
    return (dst != REG_ZERO) && ((uses_rs && (rs == dst)) || (uses_rt && (rt == dst)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear and active-low reset
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use stall, branch flush and memory-wait freeze control for the 5-stage core
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT       = 255,
  parameter int CNT_W             = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             PCWriteEn,
  output logic             PipeWriteEn,
  output logic             IdExBubble,
  output logic             IfIdFlush,
  output logic             ExMemHold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [2:0]  LS_INIT = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [15:0] TO_LAST = 16'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d, eff_state;
  logic [2:0]  rem_q, rem_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic        hazard, memwait;
  logic [15:0] wait_cnt;

  assign hazard  = idex_memread && operand_match(id_rs, id_rt, id_uses_rs, id_uses_rt, idex_rt);
  assign memwait = dmem_req && !dmem_ready;

  // Leaving MEM_WAIT behaves as the resumed state in the same cycle, so resolve it up front.
  always_comb begin
    case (state_q)
      LOAD_STALL: eff_state = LOAD_STALL;
      MEM_WAIT:   eff_state = (rem_q != 3'd0) ? LOAD_STALL : RUN;
      default:    eff_state = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= RUN;
      rem_q         <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  always_comb begin
    state_d = eff_state;
    rem_d   = rem_q;
    if (memwait) begin
      state_d = MEM_WAIT;
    end else if (eff_state == LOAD_STALL) begin
      if (rem_q <= 3'd1) begin
        state_d = RUN;
        rem_d   = '0;
      end else begin
        rem_d = rem_q - 3'd1;
      end
    end else if (hazard && (LOAD_STALL_CYCLES > 1)) begin
      state_d = LOAD_STALL;
      rem_d   = LS_INIT;
    end
  end

  always_comb begin
    PCWriteEn   = 1'b1;
    PipeWriteEn = 1'b1;
    IdExBubble  = 1'b0;
    IfIdFlush   = 1'b0;
    ExMemHold   = 1'b0;
    if (!reset) begin
      PCWriteEn   = 1'b0;
      PipeWriteEn = 1'b0;
      IdExBubble  = 1'b1;
      IfIdFlush   = 1'b1;
    end else if (memwait) begin
      PCWriteEn   = 1'b0;
      PipeWriteEn = 1'b0;
      ExMemHold   = 1'b1;
    end else if ((eff_state == LOAD_STALL) || hazard) begin
      PCWriteEn   = 1'b0;
      PipeWriteEn = 1'b0;
      IdExBubble  = 1'b1;
    end else if (branch_taken) begin
      IfIdFlush = 1'b1;
    end
  end

  assign mem_timeout_d = mem_timeout_q || (memwait && (wait_cnt >= TO_LAST));
  assign mem_timeout   = mem_timeout_q;

  sat_counter #(.W(16)) u_wait_cnt (
    .clk_i  (clock),
    .rst_ni (reset),
    .inc_i  (memwait),
    .clr_i  (!memwait),
    .cnt_o  (wait_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i  (clock),
    .rst_ni (reset),
    .inc_i  (!PipeWriteEn),
    .clr_i  (1'b0),
    .cnt_o  (stall_cycles)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl across three parameter sets
module tb_pipe_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, idex_rt;
  logic       id_uses_rs, id_uses_rt, idex_memread, branch_taken, dmem_req, dmem_ready;

  // {PCWriteEn, PipeWriteEn, IdExBubble, IfIdFlush, ExMemHold}
  logic [4:0]  o0, o1, o2;
  logic        t0, t1, t2;
  logic [15:0] sc0, sc2;
  logic [3:0]  sc1;

  localparam logic [4:0] NORMAL = 5'b11000;
  localparam logic [4:0] BUBBLE = 5'b00100;
  localparam logic [4:0] FLUSH  = 5'b11010;
  localparam logic [4:0] HOLD   = 5'b00001;
  localparam logic [4:0] RST    = 5'b00110;

  int runs  = 0;
  int fails = 0;

  always #5 clock = ~clock;

  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(255), .CNT_W(16)) u0 (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .idex_memread(idex_memread), .idex_rt(idex_rt),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .PCWriteEn(o0[4]), .PipeWriteEn(o0[3]), .IdExBubble(o0[2]), .IfIdFlush(o0[1]),
    .ExMemHold(o0[0]), .mem_timeout(t0), .stall_cycles(sc0));

  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(2), .MEM_TIMEOUT(4), .CNT_W(4)) u1 (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .idex_memread(idex_memread), .idex_rt(idex_rt),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .PCWriteEn(o1[4]), .PipeWriteEn(o1[3]), .IdExBubble(o1[2]), .IfIdFlush(o1[1]),
    .ExMemHold(o1[0]), .mem_timeout(t1), .stall_cycles(sc1));

  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(4), .CNT_W(16)) u2 (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .idex_memread(idex_memread), .idex_rt(idex_rt),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .PCWriteEn(o2[4]), .PipeWriteEn(o2[3]), .IdExBubble(o2[2]), .IfIdFlush(o2[1]),
    .ExMemHold(o2[0]), .mem_timeout(t2), .stall_cycles(sc2));

  logic [4:0] ov[3];
  logic       tv[3];
  int         scv[3];
  always_comb begin
    ov[0] = o0;  ov[1] = o1;  ov[2] = o2;
    tv[0] = t0;  tv[1] = t1;  tv[2] = t2;
    scv[0] = {16'd0, sc0};
    scv[1] = {28'd0, sc1};
    scv[2] = {16'd0, sc2};
  end

  // Reference model: bubbles still owed, consecutive wait cycles, sticky flag, stall count.
  int m_left[3], m_wait[3], m_sc[3];
  bit m_tmo[3];
  int LSC[3]  = '{1, 2, 3};
  int MTO[3]  = '{255, 4, 4};
  int SMAX[3] = '{65535, 15, 65535};

  function automatic bit ref_hazard();
    if (!idex_memread || idex_rt == 5'd0) return 1'b0;
    return (id_uses_rs && id_rs == idex_rt) || (id_uses_rt && id_rt == idex_rt);
  endfunction

  function automatic logic [4:0] ref_out(int i);
    if (!reset) return RST;
    if (dmem_req && !dmem_ready) return HOLD;
    if (m_left[i] > 0 || ref_hazard()) return BUBBLE;
    if (branch_taken) return FLUSH;
    return NORMAL;
  endfunction

  task automatic ref_clock();
    logic [4:0] e;
    for (int i = 0; i < 3; i++) begin
      e = ref_out(i);
      if (!reset) begin
        m_left[i] = 0; m_wait[i] = 0; m_sc[i] = 0; m_tmo[i] = 1'b0;
      end else begin
        if (!e[3] && m_sc[i] < SMAX[i]) m_sc[i]++;
        if (e == HOLD) begin
          m_wait[i]++;
          if (m_wait[i] >= MTO[i]) m_tmo[i] = 1'b1;
        end else begin
          m_wait[i] = 0;
          if (m_left[i] > 0) m_left[i]--;
          else if (e == BUBBLE) m_left[i] = LSC[i] - 1;
        end
      end
    end
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    idex_memread = 1'b0; idex_rt = '0; branch_taken = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle();
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) begin
      m_left[i] = 0; m_wait[i] = 0; m_sc[i] = 0; m_tmo[i] = 1'b0;
    end
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; idex_memread = 1'b1; idex_rt = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
    id_rt = 5'd0; id_uses_rt = 1'b0; branch_taken = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
    #2;
    runs++; if (o0 !== RST) begin fails++; $display("FAIL reset_out_u0 got %b want %b", o0, RST); end
    runs++; if (o2 !== RST) begin fails++; $display("FAIL reset_out_u2 got %b want %b", o2, RST); end
    @(posedge clock); #1;
    @(posedge clock); #1;
    runs++; if (sc0 !== 16'd0) begin fails++; $display("FAIL reset_stall_cnt got %0d want 0", sc0); end
    runs++; if (t1 !== 1'b0) begin fails++; $display("FAIL reset_timeout got %b want 0", t1); end
    reset = 1'b1;
    idle();
  endtask

  task automatic test_load_use();
    do_reset();
    idex_memread = 1'b1; idex_rt = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
    #2;
    runs++; if (o0 !== BUBBLE) begin fails++; $display("FAIL lu_stall got %b want %b", o0, BUBBLE); end
    @(posedge clock); #1;
    idex_memread = 1'b0;
    #2;
    runs++; if (o0 !== NORMAL) begin fails++; $display("FAIL lu_resume got %b want %b", o0, NORMAL); end
    runs++; if (o1 !== BUBBLE) begin fails++; $display("FAIL lu_lsc2_second got %b want %b", o1, BUBBLE); end
    @(posedge clock); #1;
    runs++; if (sc0 !== 16'd1) begin fails++; $display("FAIL lu_stall_cnt got %0d want 1", sc0); end
    runs++; if (sc1 !== 4'd2) begin fails++; $display("FAIL lu_stall_cnt_lsc2 got %0d want 2", sc1); end
  endtask

  task automatic test_no_hazard();
    do_reset();
    idex_memread = 1'b1; idex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1; id_rt = 5'd0; id_uses_rt = 1'b1;
    #2;
    runs++; if (o0 !== NORMAL) begin fails++; $display("FAIL nh_reg0 got %b want %b", o0, NORMAL); end
    @(posedge clock); #1;
    idex_rt = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b0; id_rs = 5'd3;
    #2;
    runs++; if (o0 !== NORMAL) begin fails++; $display("FAIL nh_uses_rt0 got %b want %b", o0, NORMAL); end
    @(posedge clock); #1;
    runs++; if (sc0 !== 16'd0) begin fails++; $display("FAIL nh_stall_cnt got %0d want 0", sc0); end
    id_uses_rt = 1'b1;
    #2;
    runs++; if (o2 !== BUBBLE) begin fails++; $display("FAIL nh_rt_match got %b want %b", o2, BUBBLE); end
    @(posedge clock); #1;
  endtask

  task automatic test_branch_in_stall();
    logic [4:0] want;
    do_reset();
    idex_memread = 1'b1; idex_rt = 5'd7; id_rs = 5'd7; id_uses_rs = 1'b1; branch_taken = 1'b1;
    #2;
    runs++; if (o2 !== BUBBLE) begin fails++; $display("FAIL bs_first got %b want %b", o2, BUBBLE); end
    @(posedge clock); #1;
    idex_memread = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      #2;
      want = (c <= 3) ? BUBBLE : FLUSH;
      runs++; if (o2 !== want) begin fails++; $display("FAIL bs_cycle%0d got %b want %b", c, o2, want); end
      if (c == 2) begin
        runs++; if (o0 !== FLUSH) begin fails++; $display("FAIL bs_lsc1_flush got %b want %b", o0, FLUSH); end
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_mem_in_stall();
    do_reset();
    idex_memread = 1'b1; idex_rt = 5'd4; id_rt = 5'd4; id_uses_rt = 1'b1;
    #2;
    runs++; if (o1 !== BUBBLE) begin fails++; $display("FAIL ms_first got %b want %b", o1, BUBBLE); end
    @(posedge clock); #1;
    idex_memread = 1'b0; dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #2;
      runs++; if (o1 !== HOLD) begin fails++; $display("FAIL ms_hold%0d got %b want %b", c, o1, HOLD); end
      @(posedge clock); #1;
    end
    dmem_req = 1'b0;
    #2;
    runs++; if (o1 !== BUBBLE) begin fails++; $display("FAIL ms_resume_bubble got %b want %b", o1, BUBBLE); end
    @(posedge clock); #1;
    #2;
    runs++; if (o1 !== NORMAL) begin fails++; $display("FAIL ms_run got %b want %b", o1, NORMAL); end
    runs++; if (t1 !== 1'b1) begin fails++; $display("FAIL ms_timeout got %b want 1", t1); end
    @(posedge clock); #1;
  endtask

  task automatic test_timeout_and_reset();
    logic want;
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clock); #1;
      want = (k >= 4);
      runs++; if (t2 !== want) begin fails++; $display("FAIL to_wait%0d got %b want %b", k, t2, want); end
    end
    dmem_ready = 1'b1;
    #2;
    runs++; if (o2 !== NORMAL) begin fails++; $display("FAIL to_release got %b want %b", o2, NORMAL); end
    @(posedge clock); #1;
    runs++; if (t2 !== 1'b1) begin fails++; $display("FAIL to_sticky got %b want 1", t2); end
    idex_memread = 1'b1; idex_rt = 5'd9; id_rs = 5'd9; id_uses_rs = 1'b1;
    @(posedge clock); #1;
    idex_memread = 1'b0; dmem_ready = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    idle();
    #2;
    runs++; if (o2 !== NORMAL) begin fails++; $display("FAIL rst_no_residual got %b want %b", o2, NORMAL); end
    runs++; if (t2 !== 1'b0) begin fails++; $display("FAIL rst_timeout_clear got %b want 0", t2); end
    runs++; if (sc2 !== 16'd0) begin fails++; $display("FAIL rst_stall_clear got %0d want 0", sc2); end
    @(posedge clock); #1;
  endtask

  task automatic test_saturation();
    logic [3:0] want;
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock); #1;
      want = (k < 15) ? 4'(k) : 4'd15;
      runs++; if (sc1 !== want) begin fails++; $display("FAIL sat_k%0d got %0d want %0d", k, sc1, want); end
    end
    idle();
  endtask

  task automatic test_random();
    logic [4:0] exp;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      reset        = ($urandom_range(0, 59) != 0);
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      idex_rt      = 5'($urandom_range(0, 3));
      id_uses_rs   = 1'($urandom_range(0, 1));
      id_uses_rt   = 1'($urandom_range(0, 1));
      idex_memread = ($urandom_range(0, 2) == 0);
      branch_taken = 1'($urandom_range(0, 1));
      dmem_req     = ($urandom_range(0, 3) != 0);
      dmem_ready   = ($urandom_range(0, 2) == 0);
      #2;
      for (int i = 0; i < 3; i++) begin
        exp = ref_out(i);
        runs++; if (ov[i] !== exp) begin fails++; $display("FAIL rand_out u%0d n=%0d got %b want %b", i, n, ov[i], exp); end
      end
      @(posedge clock); #1;
      ref_clock();
      for (int i = 0; i < 3; i++) begin
        runs++; if (tv[i] !== m_tmo[i]) begin fails++; $display("FAIL rand_tmo u%0d n=%0d got %b want %b", i, n, tv[i], m_tmo[i]); end
        runs++; if (scv[i] != m_sc[i]) begin fails++; $display("FAIL rand_stall u%0d n=%0d got %0d want %0d", i, n, scv[i], m_sc[i]); end
      end
    end
    reset = 1'b1;
    idle();
  endtask

  initial begin
    reset = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch_in_stall();
    test_mem_in_stall();
    test_timeout_and_reset();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", runs, fails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage MIPS core. It drives the IF/ID register's PipeWriteEn and the PC write enable, inserts ID/EX bubbles on load-use hazards, and flushes IF/ID on taken branches. It freezes the whole pipe while data memory is not ready, with a timeout flag. It also keeps a saturating stall-cycle counter for debug.

Parameters:
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7)
MEM_TIMEOUT, 255, consecutive MEM_WAIT cycles before mem_timeout sets (1..65535)
CNT_W, 16, width of stall_cycles counter

Ports:
clock  in  1  core clock; all state updates on posedge
reset  in  1  synchronous, active-low reset
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
idex_memread  in  1  instruction in EX is a load
idex_rt  in  5  destination of load in EX
branch_taken  in  1  branch resolved taken in ID
dmem_req  in  1  MEM stage access active
dmem_ready  in  1  data memory completes access this cycle
PCWriteEn  out  1  PC may update
PipeWriteEn  out  1  IF/ID register may update
IdExBubble  out  1  zero control bits into ID/EX
IfIdFlush  out  1  replace IF/ID contents with NOP
ExMemHold  out  1  hold EX/MEM and MEM/WB registers
mem_timeout  out  1  sticky memory-timeout flag
stall_cycles  out  CNT_W  saturating count of cycles with PipeWriteEn=0

Behaviour:
- States: RUN, LOAD_STALL, MEM_WAIT. Encoding lives in the package.
- Reset (reset==0 at posedge): state=RUN, stall counter=0, timeout counter=0, mem_timeout=0, stall_cycles=0.
- Outputs while reset==0 (combinational): PCWriteEn=0, PipeWriteEn=0, IdExBubble=1, IfIdFlush=1, ExMemHold=0.
- Reset asserted mid-stall or mid-wait returns to RUN with no residual bubbles.
- hazard = idex_memread & (idex_rt!=0) & ((id_uses_rs & id_rs==idex_rt) | (id_uses_rt & id_rt==idex_rt)). Register $0 never hazards.
- memwait = dmem_req & ~dmem_ready.
- Priority each cycle: memwait > hazard/LOAD_STALL > branch_taken > normal.
- RUN, normal: PCWriteEn=1, PipeWriteEn=1, IdExBubble=0, IfIdFlush=0, ExMemHold=0.
- RUN, hazard: PCWriteEn=0, PipeWriteEn=0, IdExBubble=1, IfIdFlush=0.
  - If LOAD_STALL_CYCLES>1, go to LOAD_STALL with remaining = LOAD_STALL_CYCLES-1.
  - Otherwise stay in RUN.
- LOAD_STALL: same outputs as hazard. Decrement remaining each cycle; return to RUN when remaining reaches 1. Total bubbles = LOAD_STALL_CYCLES exactly.
- branch_taken is ignored while hazard or LOAD_STALL is active; the branch re-evaluates after the stall.
- RUN, branch_taken, no hazard: IfIdFlush=1, PCWriteEn=1, PipeWriteEn=1.
- memwait in any state: go to or remain in MEM_WAIT; the LOAD_STALL remaining count is saved.
- MEM_WAIT outputs: PCWriteEn=0, PipeWriteEn=0, IdExBubble=0, IfIdFlush=0, ExMemHold=1.
- MEM_WAIT exit on dmem_ready or ~dmem_req: return to LOAD_STALL if remaining>0, else RUN. The exit cycle has that destination state's outputs, evaluated the same cycle.
- Timeout counter increments each MEM_WAIT cycle and clears on exit. When it reaches MEM_TIMEOUT, mem_timeout=1 (sticky until reset). The FSM keeps waiting.
- stall_cycles increments on every posedge where PipeWriteEn==0 and reset==1; it saturates at all-ones.
- All outputs except mem_timeout and stall_cycles are combinational from state and inputs. No extra latency: a hazard stalls in the same cycle it is detected.

Decomposition:
- Package hazard_pkg:
  - state enum (RUN, LOAD_STALL, MEM_WAIT)
  - REG_ZERO=5'd0
  - function operand_match(rs, rt, uses_rs, uses_rt, dst)
- One sub-module, sat_counter (parameterised width, inc, clear, synchronous active-low reset). It is instantiated for stall_cycles and for the timeout counter.

Test Plan:
- lw $5 in EX (idex_memread=1, idex_rt=5), ID rs=5 uses_rs=1, LOAD_STALL_CYCLES=1 -> exactly one cycle with PCWriteEn=0, PipeWriteEn=0, IdExBubble=1; next cycle all enables 1; stall_cycles=1.
- Same with idex_rt=0, rs=0 -> no stall. Same with rt=5 but uses_rt=0 -> no stall.
- LOAD_STALL_CYCLES=3, hazard plus branch_taken=1 throughout -> 3 bubble cycles with IfIdFlush=0; first post-stall cycle IfIdFlush=1.
- LOAD_STALL_CYCLES=2, hazard, then dmem_req=1/dmem_ready=0 for 4 cycles during LOAD_STALL -> ExMemHold=1 for 4 cycles with IdExBubble=0, then 1 remaining bubble, then RUN.
- MEM_TIMEOUT=4, dmem_ready held 0 for 10 cycles -> mem_timeout rises after the 4th wait cycle and stays 1 after dmem_ready=1; only reset=0 clears it.
- reset=0 asserted mid-MEM_WAIT -> next cycle after release: state RUN, stall_cycles=0, mem_timeout=0, all enables 1; saturation check with CNT_W=4 -> holds at 15.
